vdp_vram_arb: RTL and testbench
===============================

// Module: vdp_vram_arb
// PURPOSE
//  VRAM port owner/responder for the VDP. Serves vdp_fsm's DMA read requests (vdp_dma_addr/vdp_dma_rd_tick
//  -> vram_dout) and fits CPU data-port traffic (TMS9918-style auto-increment write/prefetch) into the
//  slots the FSM leaves idle. Sits between vdp_fsm, the CPU register decoder and the single-port VRAM.
// PARAMETERS
//  ADDR_W  14  VRAM address width (16KB)
//  DATA_W  8   VRAM data width
// PORTS
//  pxclk          in   1       pixel clock, 25MHz
//  reset          in   1       synchronous, active-high
//  dma_addr       in   ADDR_W  VDP DMA read address (from vdp_fsm)
//  dma_rd_tick    in   1       VDP DMA read request; held 2 pxclk per access
//  vram_dout      out  DATA_W  read data returned to vdp_fsm
//  cpu_addr       in   ADDR_W  new CPU VRAM address
//  cpu_addr_tick  in   1       load cpu_addr into address pointer
//  cpu_addr_rd    in   1       with cpu_addr_tick: 1 = also start a prefetch
//  cpu_wr_tick    in   1       CPU data-port write of cpu_wdata
//  cpu_wdata      in   DATA_W  CPU write data
//  cpu_rd_tick    in   1       CPU data-port read: consume cpu_rdata, start next prefetch
//  cpu_rdata      out  DATA_W  read-ahead buffer
//  cpu_busy       out  1       CPU op pending/in progress
//  cpu_ovf        out  1       1-pxclk pulse: CPU data-port tick dropped while busy
//  ram_addr       out  ADDR_W  VRAM address
//  ram_we         out  1       VRAM write enable
//  ram_wdata      out  DATA_W  VRAM write data
//  ram_rdata      in   DATA_W  VRAM sync read data, 1-pxclk latency
// BEHAVIOUR
//  - Reset: state IDLE, ptr=0, cpu_rdata=0, cpu_busy=0, cpu_ovf=0, ram_we=0; vram_dout follows ram_rdata.
//  - DMA absolute priority: any cycle with dma_rd_tick=1 -> ram_addr=dma_addr, ram_we=0 (combinational).
//  - vram_dout = ram_rdata, unregistered. Data for an address driven in cycle N is valid in cycle N+1;
//    the 2nd cycle of a dma_rd_tick window guarantees valid data at the edge that ends it (FSM sample edge).
//  - CPU FSM states: IDLE, WR_PEND, RD_PEND, RD_WAIT.
//    IDLE: cpu_wr_tick -> latch pend_addr=ptr, pend_data=cpu_wdata, ptr+=1, ->WR_PEND.
//          cpu_rd_tick, or cpu_addr_tick with cpu_addr_rd=1 -> pend_addr=ptr(after load), ptr+=1, ->RD_PEND.
//    WR_PEND: first cycle with dma_rd_tick=0 -> ram_addr=pend_addr, ram_we=1, ram_wdata=pend_data, ->IDLE.
//    RD_PEND: first cycle with dma_rd_tick=0 -> ram_addr=pend_addr, ram_we=0, ->RD_WAIT.
//    RD_WAIT: unconditionally cpu_rdata<=ram_rdata (valid even if DMA owns the port now), ->IDLE.
//  - cpu_busy = (state!=IDLE); also 1 in the cycle a request is accepted (combinational on ticks).
//  - cpu_addr_tick: always accepted; ptr<=cpu_addr. If state=RD_PEND (unissued), prefetch is re-targeted
//    to cpu_addr (cpu_addr_rd=1) or cancelled ->IDLE (cpu_addr_rd=0). WR_PEND/RD_WAIT unaffected.
//  - cpu_wr_tick/cpu_rd_tick while busy: dropped, ptr unchanged, cpu_ovf=1 one pxclk.
//  - Simultaneous cpu_addr_tick and cpu_wr_tick/cpu_rd_tick in IDLE: address load wins, data tick dropped, cpu_ovf=1.
//  - ptr wraps 14'h3FFF -> 0; pend_addr is ADDR_W wide, no carry out.
//  - Worst-case CPU wait with vdp_fsm ring: 4 consecutive DMA cycles (slots 2,3) -> op issues within 5 pxclk;
//    during blanking (no DMA) op issues next cycle.
//  - ram_we never 1 when dma_rd_tick=1 or in reset.
// STRUCTURE
//  - CPU FSM state encoding + ADDR_W/DATA_W defaults in shared vdp_defs.vh (used by vdp_fsm/regs too).
//  - Single module; no sub-module. Port mux is combinational, CPU FSM/ptr/buffers registered.
// TESTING
//  - DMA only: dma_addr=0x1234 2-cycle ticks, RAM model 0x1234=0xA5 -> vram_dout=0xA5 at sample edge, ram_we=0.
//  - cpu_addr_tick addr=0x0800 rd=0, 3x cpu_wr_tick 11,22,33 spaced 8 clk -> RAM 0x800..0x802=11,22,33, ptr=0x803.
//  - cpu_addr_tick addr=0x3FFF rd=1, RAM 0x3FFF=0x5A -> cpu_rdata=0x5A, ptr=0x0000; cpu_rd_tick prefetches 0x0000.
//  - CPU write during DMA slots 2,3 (4-cycle tick) -> write issued 1st cycle after tick drops, DMA data intact.
//  - cpu_wr_tick twice back-to-back during DMA -> 2nd dropped, cpu_ovf 1-cycle pulse, only 1st write lands.
//  - RD_PEND blocked by DMA, cpu_addr_tick 0x0100 rd=1 -> prefetch reads 0x0100 not old ptr; reset mid-op -> IDLE, no write.

Source files
------------

// File: rtl/vdp_vram_arb_pkg.sv
// Shared definitions for the VDP VRAM arbiter.
//   VRAM_ADDR_W / VRAM_DATA_W : default VRAM geometry (16KB x 8)
//   cpu_state_e               : CPU data-port sequencer states
package vdp_vram_arb_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no CPU op outstanding
    ST_WR_PEND = 2'd1,  // write latched, waiting for a free VRAM slot
    ST_RD_PEND = 2'd2,  // prefetch latched, waiting for a free VRAM slot
    ST_RD_WAIT = 2'd3   // prefetch address issued, data arrives this cycle
  } cpu_state_e;

endpackage

// File: rtl/vdp_vram_arb.sv
// VRAM port owner for the VDP. Display DMA reads from vdp_fsm always own the
// single-port VRAM; CPU data-port writes and read-ahead prefetches are held in
// a one-deep pending slot and issued in the first cycle the DMA leaves idle.
//
// Ports
//   pxclk, reset            pixel clock, synchronous active-high reset
//   dma_addr, dma_rd_tick   DMA read request (tick held 2 pxclk per access)
//   vram_dout               DMA read data (unregistered ram_rdata)
//   cpu_addr, cpu_addr_tick load the CPU address pointer
//   cpu_addr_rd             with cpu_addr_tick: also start a prefetch
//   cpu_wr_tick, cpu_wdata  CPU data-port write
//   cpu_rd_tick             CPU data-port read: consume buffer, prefetch next
//   cpu_rdata               read-ahead buffer
//   cpu_busy                CPU op accepted this cycle or still outstanding
//   cpu_ovf                 one-cycle pulse after a dropped data-port tick
//   ram_addr/we/wdata/rdata VRAM port, sync read with 1-pxclk latency
module vdp_vram_arb
  import vdp_vram_arb_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              pxclk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_rd_tick,
  output logic [DATA_W-1:0] vram_dout,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_addr_tick,
  input  logic              cpu_addr_rd,
  input  logic              cpu_wr_tick,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rd_tick,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic              cpu_ovf,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  cpu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ovf_q, cpu_ovf_d;
  logic              cpu_we;     // pending write goes to VRAM this cycle
  logic              data_tick;

  assign data_tick = cpu_wr_tick | cpu_rd_tick;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ovf_d   = 1'b0;
    cpu_we      = 1'b0;
    cpu_busy    = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (cpu_addr_tick) begin
          // Address load wins; a data tick in the same cycle is dropped.
          ptr_d     = cpu_addr;
          cpu_ovf_d = data_tick;
          if (cpu_addr_rd) begin
            pend_addr_d = cpu_addr;
            ptr_d       = cpu_addr + ADDR_W'(1);
            state_d     = ST_RD_PEND;
            cpu_busy    = 1'b1;
          end
        end else if (cpu_wr_tick) begin
          pend_addr_d = ptr_q;
          pend_data_d = cpu_wdata;
          ptr_d       = ptr_q + ADDR_W'(1);
          state_d     = ST_WR_PEND;
          cpu_busy    = 1'b1;
          cpu_ovf_d   = cpu_rd_tick;
        end else if (cpu_rd_tick) begin
          pend_addr_d = ptr_q;
          ptr_d       = ptr_q + ADDR_W'(1);
          state_d     = ST_RD_PEND;
          cpu_busy    = 1'b1;
        end
      end

      ST_WR_PEND: begin
        if (cpu_addr_tick) ptr_d = cpu_addr;
        cpu_ovf_d = data_tick;
        if (!dma_rd_tick) begin
          cpu_we  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_RD_PEND: begin
        cpu_ovf_d = data_tick;
        if (cpu_addr_tick) begin
          // Prefetch not yet issued: follow the new address or abandon it.
          ptr_d = cpu_addr;
          if (cpu_addr_rd) begin
            pend_addr_d = cpu_addr;
            ptr_d       = cpu_addr + ADDR_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!dma_rd_tick) begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        // Data for the address issued last cycle is on ram_rdata now, even if
        // DMA has taken the port back this cycle.
        if (cpu_addr_tick) ptr_d = cpu_addr;
        cpu_ovf_d   = data_tick;
        cpu_rdata_d = ram_rdata;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Port mux: DMA owns the port whenever it asks; otherwise the pending CPU
  // address is presented (a harmless read when no CPU op is issuing).
  assign ram_addr  = dma_rd_tick ? dma_addr : pend_addr_q;
  assign ram_we    = cpu_we & ~dma_rd_tick & ~reset;
  assign ram_wdata = pend_data_q;
  assign vram_dout = ram_rdata;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ovf   = cpu_ovf_q;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge pxclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      cpu_rdata_q <= '0;
      cpu_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ovf_q   <= cpu_ovf_d;
    end
  end

endmodule

// File: tb/tb_vdp_vram_arb.sv
// Self-checking bench for vdp_vram_arb: a behavioural VRAM, directed scenarios
// for DMA priority, auto-increment writes, prefetch wrap, overflow drops,
// prefetch re-targeting and reset mid-op, then a randomized phase checked
// against a reference model (expected memory image + address pointer).
module tb_vdp_vram_arb;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int MEM_N = 1 << AW;

  logic          pxclk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] dma_addr = '0;
  logic          dma_rd_tick = 1'b0;
  logic [DW-1:0] vram_dout;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_addr_tick = 1'b0;
  logic          cpu_addr_rd = 1'b0;
  logic          cpu_wr_tick = 1'b0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_rd_tick = 1'b0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_busy;
  logic          cpu_ovf;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  vdp_vram_arb dut (
    .pxclk        (pxclk),
    .reset        (reset),
    .dma_addr     (dma_addr),
    .dma_rd_tick  (dma_rd_tick),
    .vram_dout    (vram_dout),
    .cpu_addr     (cpu_addr),
    .cpu_addr_tick(cpu_addr_tick),
    .cpu_addr_rd  (cpu_addr_rd),
    .cpu_wr_tick  (cpu_wr_tick),
    .cpu_wdata    (cpu_wdata),
    .cpu_rd_tick  (cpu_rd_tick),
    .cpu_rdata    (cpu_rdata),
    .cpu_busy     (cpu_busy),
    .cpu_ovf      (cpu_ovf),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 pxclk = ~pxclk;

  // Power-up VRAM contents; a few addresses carry the directed-test values.
  function automatic logic [DW-1:0] init_val(int a);
    case (a)
      'h1234:  return 8'hA5;
      'h3FFF:  return 8'h5A;
      'h0000:  return 8'hC3;
      'h0803:  return 8'h77;
      'h2000:  return 8'h3C;
      'h0100:  return 8'h4D;
      default: return 8'((a * 37) ^ (a >> 6) ^ 'h5B);
    endcase
  endfunction

  // Behavioural single-port VRAM, sync read, read-before-write.
  logic [DW-1:0] mem [0:MEM_N-1];
  logic          mem_ready = 1'b0;
  always @(posedge pxclk) begin
    if (!mem_ready) begin
      for (int i = 0; i < MEM_N; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: expected memory image, CPU pointer, expected buffer.
  logic [DW-1:0] ref_mem [0:MEM_N-1];
  logic [AW-1:0] ref_ptr = '0;
  logic [DW-1:0] exp_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  // DMA driver state: remaining cycles of the current window (incl. this one).
  int            dma_left = 0;
  logic [AW-1:0] dma_cur = '0;
  bit            dma_rand = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_dma(input logic [AW-1:0] a, input int len);
    dma_cur     = a;
    dma_left    = len;
    dma_addr    = a;
    dma_rd_tick = 1'b1;
  endtask

  // Advance DMA for the next cycle; random windows always leave a gap cycle,
  // like the slot ring of vdp_fsm.
  task automatic dma_next();
    bit was_dma;
    was_dma = dma_rd_tick;
    if (dma_left > 0) dma_left--;
    if (dma_left == 0 && !was_dma && dma_rand && $urandom_range(0, 3) == 0) begin
      dma_left = ($urandom_range(0, 1) == 1) ? 4 : 2;
      dma_cur  = 14'h2000 + AW'($urandom_range(0, 'hFFF));
    end
    dma_rd_tick = (dma_left > 0);
    dma_addr    = dma_cur;
  endtask

  // One pxclk: DMA-side checks before the edge, clear CPU ticks after it.
  task automatic step();
    #2;
    if (dma_rd_tick) begin
      check("dma_no_we", 32'(ram_we), 32'd0);
      check("dma_addr", 32'(ram_addr), 32'(dma_cur));
      if (dma_left == 1) check("dma_dout", 32'(vram_dout), 32'(ref_mem[dma_cur]));
    end
    @(posedge pxclk);
    #1;
    cpu_addr_tick = 1'b0;
    cpu_addr_rd   = 1'b0;
    cpu_wr_tick   = 1'b0;
    cpu_rd_tick   = 1'b0;
    dma_next();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cpu_busy && n < 20) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(cpu_busy), 32'd0);
  endtask

  task automatic cpu_write(input logic [DW-1:0] d);
    cpu_wdata        = d;
    cpu_wr_tick      = 1'b1;
    ref_mem[ref_ptr] = d;
    ref_ptr++;
    step();
  endtask

  task automatic cpu_read();
    exp_rdata   = ref_mem[ref_ptr];
    ref_ptr++;
    cpu_rd_tick = 1'b1;
    step();
  endtask

  task automatic cpu_load(input logic [AW-1:0] a, input bit rd);
    cpu_addr      = a;
    cpu_addr_tick = 1'b1;
    cpu_addr_rd   = rd;
    ref_ptr       = a;
    if (rd) begin
      exp_rdata = ref_mem[a];
      ref_ptr++;
    end
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bad;
    bit  pend;
    bit  rd;
    int  r;
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = init_val(i);
    #1;

    // Reset state.
    reset = 1'b1;
    repeat (3) step();
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_busy", 32'(cpu_busy), 32'd0);
    check("rst_ovf", 32'(cpu_ovf), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_dout", 32'(vram_dout), 32'(ram_rdata));
    reset = 1'b0;
    step();

    // DMA only: 2-cycle window at 0x1234, data valid at the sample edge.
    start_dma(14'h1234, 2);
    step();
    step();
    step();

    // Auto-increment writes at 0x0800, spaced 8 pxclk.
    cpu_load(14'h0800, 1'b0);
    cpu_wdata   = 8'h11;
    cpu_wr_tick = 1'b1;
    #1;
    check("busy_on_accept", 32'(cpu_busy), 32'd1);
    ref_mem[ref_ptr] = 8'h11;
    ref_ptr++;
    step();
    #1;
    check("wr_issue_we", 32'(ram_we), 32'd1);
    check("wr_issue_addr", 32'(ram_addr), 32'h0800);
    check("wr_issue_data", 32'(ram_wdata), 32'h11);
    repeat (7) step();
    cpu_write(8'h22);
    repeat (7) step();
    cpu_write(8'h33);
    repeat (7) step();
    check("wr_done_idle", 32'(cpu_busy), 32'd0);
    cpu_read();
    wait_idle();
    check("ptr_after_writes", 32'(cpu_rdata), 32'h77);

    // Prefetch at 0x3FFF, then pointer wraps to 0x0000.
    cpu_load(14'h3FFF, 1'b1);
    wait_idle();
    check("prefetch_3fff", 32'(cpu_rdata), 32'h5A);
    cpu_read();
    wait_idle();
    check("prefetch_wrap", 32'(cpu_rdata), 32'hC3);

    // Write accepted during a 4-cycle DMA window issues right after it.
    start_dma(14'h2000, 4);
    cpu_write(8'h99);
    repeat (3) step();
    #1;
    check("wr_after_dma_we", 32'(ram_we), 32'd1);
    check("wr_after_dma_addr", 32'(ram_addr), 32'h0001);
    check("wr_after_dma_data", 32'(ram_wdata), 32'h99);
    step();

    // Back-to-back writes during DMA: second dropped with a 1-cycle ovf pulse.
    start_dma(14'h2002, 4);
    cpu_write(8'hAB);
    cpu_wdata   = 8'hCD;
    cpu_wr_tick = 1'b1;
    step();
    check("ovf_pulse", 32'(cpu_ovf), 32'd1);
    step();
    check("ovf_clear", 32'(cpu_ovf), 32'd0);
    wait_idle();
    cpu_read();
    wait_idle();
    check("drop_no_write", 32'(cpu_rdata), 32'(exp_rdata));

    // Address load and data tick together in IDLE: load wins, data dropped.
    cpu_addr      = 14'h0400;
    cpu_addr_tick = 1'b1;
    cpu_addr_rd   = 1'b0;
    cpu_wdata     = 8'hEE;
    cpu_wr_tick   = 1'b1;
    ref_ptr       = 14'h0400;
    step();
    check("ovf_simul", 32'(cpu_ovf), 32'd1);
    check("simul_idle", 32'(cpu_busy), 32'd0);
    cpu_read();
    wait_idle();
    check("simul_ptr", 32'(cpu_rdata), 32'(exp_rdata));

    // Prefetch blocked by DMA is re-targeted by a new address load.
    start_dma(14'h2001, 4);
    cpu_rd_tick = 1'b1;
    step();
    cpu_addr      = 14'h0100;
    cpu_addr_tick = 1'b1;
    cpu_addr_rd   = 1'b1;
    ref_ptr       = 14'h0101;
    step();
    wait_idle();
    check("retarget", 32'(cpu_rdata), 32'h4D);

    // Reset while a write is pending behind DMA: no write ever issues.
    start_dma(14'h2003, 4);
    cpu_wdata   = 8'h5F;
    cpu_wr_tick = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ref_ptr = '0;
    for (int i = 0; i < 4; i++) begin
      check("rst_mid_no_we", 32'(ram_we), 32'd0);
      step();
    end
    check("rst_mid_busy", 32'(cpu_busy), 32'd0);
    check("rst_mid_rdata", 32'(cpu_rdata), 32'd0);
    cpu_read();
    wait_idle();
    check("rst_mid_ptr", 32'(cpu_rdata), 32'hC3);

    // Randomized traffic with random DMA windows in the 0x2000-0x2FFF region.
    dma_rand = 1'b1;
    cpu_load(AW'($urandom_range(0, 'hFFF)), 1'b0);
    pend = 1'b0;
    for (int k = 0; k < 150; k++) begin
      wait_idle();
      if (pend) check("rand_rdata", 32'(cpu_rdata), 32'(exp_rdata));
      pend = 1'b0;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        cpu_write(DW'($urandom));
      end else if (r < 8) begin
        cpu_read();
        pend = 1'b1;
      end else begin
        rd = 1'($urandom_range(0, 1));
        cpu_load(AW'($urandom_range(0, 'hFFF)), rd);
        pend = rd;
      end
    end
    wait_idle();
    if (pend) check("rand_rdata", 32'(cpu_rdata), 32'(exp_rdata));
    dma_rand = 1'b0;
    repeat (6) step();

    // Whole VRAM image against the reference model.
    bad = 0;
    for (int i = 0; i < MEM_N; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
